// File: rtl/apb_slave_bank.sv
// APB completer bank: NUM_SLAVES register-file peripherals of DEPTH words each.
// Programmable wait states, error response on bad select/offset, abort on select change.
module apb_slave_bank #(
   parameter int NUM_SLAVES  = 3,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0,
   parameter int OFFSET_BITS = 12
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic [NUM_SLAVES-1:0] Pselx,
   input  logic                  Penable,
   input  logic                  Pwrite,
   input  logic [31:0]           Paddr,
   input  logic [DATA_W-1:0]     Pwdata,
   output logic [DATA_W-1:0]     Prdata,
   output logic                  Pready,
   output logic                  Pslverr
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                  state_reg, state_next;
   logic [3:0]              cnt_reg, cnt_next;
   logic [NUM_SLAVES-1:0]   sel_reg;
   logic                    write_reg;
   logic [AW-1:0]           word_reg;
   logic [DATA_W-1:0]       wdata_reg;
   logic                    err_reg;

   logic                    setup;
   logic                    multi_sel;
   logic                    addr_err;
   logic [OFFSET_BITS-1:0]  offset;
   logic [NUM_SLAVES-1:0][DATA_W-1:0] bank_rd;
   logic [DATA_W-1:0]       rd_word;
   logic                    unused_addr;

   assign offset      = Paddr[OFFSET_BITS-1:0];
   assign unused_addr = &{1'b0, Paddr[31:OFFSET_BITS]};
   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign multi_sel   = (Pselx & (Pselx - NUM_SLAVES'(1))) != '0;
   assign addr_err    = (offset[1:0] != 2'b00) || ((offset >> (AW + 2)) != '0);
   assign setup       = (state_reg == IDLE) && (|Pselx) && !Penable;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      Pready     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (setup) begin
               state_next = ACCESS;
               cnt_next   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (Pselx != sel_reg) begin
               state_next = IDLE;
            end else if (Penable) begin
               if (cnt_reg != 4'd0) begin
                  cnt_next = cnt_reg - 4'd1;
               end else begin
                  Pready     = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         sel_reg   <= '0;
         write_reg <= 1'b0;
         word_reg  <= '0;
         wdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (setup) begin
            sel_reg   <= Pselx;
            write_reg <= Pwrite;
            word_reg  <= Paddr[AW+1:2];
            wdata_reg <= Pwdata;
            err_reg   <= multi_sel || addr_err;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_bank
         logic [DATA_W-1:0] mem_reg [DEPTH];

         always_ff @(posedge Hclk or posedge Hreset) begin
            if (Hreset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem_reg[i] <= '0;
               end
            end else if (Pready && write_reg && !err_reg && sel_reg[gi]) begin
               mem_reg[word_reg] <= wdata_reg;
            end
         end

         assign bank_rd[gi] = sel_reg[gi] ? mem_reg[word_reg] : '0;
      end
   endgenerate

   // An error-free latched select is one-hot, so OR-ing the banks picks exactly one.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         rd_word = rd_word | bank_rd[i];
      end
   end

   assign Prdata  = (Pready && !write_reg && !err_reg) ? rd_word : '0;
   assign Pslverr = Pready && err_reg;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench: three banks built with 0, 3 and 2 wait states share one APB master.
module tb_apb_slave_bank;

   logic        Hclk;
   logic        Hreset;
   logic [2:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [2:0]        pready_v;
   logic [2:0]        pslverr_v;
   logic [2:0][31:0]  prdata_v;

   int compared;
   int mismatched;
   int cur;

   apb_slave_bank #(.WAIT_STATES(0)) dut0 (
      .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_v[0]), .Pready(pready_v[0]),
      .Pslverr(pslverr_v[0]));
   apb_slave_bank #(.WAIT_STATES(3)) dut1 (
      .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_v[1]), .Pready(pready_v[1]),
      .Pslverr(pslverr_v[1]));
   apb_slave_bank #(.WAIT_STATES(2)) dut2 (
      .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_v[2]), .Pready(pready_v[2]),
      .Pslverr(pslverr_v[2]));

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   typedef struct {
      logic [2:0]  sel;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      Hreset  = 1'b1;
      Pselx   = '0;
      Penable = 1'b0;
      repeat (2) @(posedge Hclk);
      #1 Hreset = 1'b0;
   endtask

   task automatic bus_idle();
      @(posedge Hclk);
      #1;
      Pselx   = '0;
      Penable = 1'b0;
   endtask

   // One APB transfer against DUT 'cur'; Prdata/Pslverr must stay 0 while waiting.
   task automatic apb(input logic [2:0] sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int waits);
      bit done;
      @(posedge Hclk);
      #1;
      Pselx = sel; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wd;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      waits = 0; rd = '0; er = 1'b0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Hclk);
         if (pready_v[cur]) begin
            rd   = prdata_v[cur];
            er   = pslverr_v[cur];
            done = 1'b1;
         end else begin
            waits++;
            chk("wait_outputs", {31'd0, pslverr_v[cur]} | prdata_v[cur], 32'd0);
         end
      end
      if (!done) chk("pready_timeout", 32'd0, 32'd1);
      $display("dut%0d %s sel=%b addr=%h wdata=%h -> rdata=%h err=%b waits=%0d",
               cur, wr ? "WR" : "RD", sel, addr, wd, rd, er, waits);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          w;
      compared = 0; mismatched = 0; cur = 0;
      Pwrite = 1'b0; Paddr = '0; Pwdata = '0;

      vecs[0]  = '{3'b001, 1'b1, 32'h8,         32'h0000000A, 32'h0,        1'b0};
      vecs[1]  = '{3'b100, 1'b1, 32'h8,         32'h0000000B, 32'h0,        1'b0};
      vecs[2]  = '{3'b001, 1'b0, 32'h8,         32'h0,        32'h0000000A, 1'b0};
      vecs[3]  = '{3'b100, 1'b0, 32'h8,         32'h0,        32'h0000000B, 1'b0};
      vecs[4]  = '{3'b010, 1'b0, 32'h8,         32'h0,        32'h0,        1'b0};
      vecs[5]  = '{3'b010, 1'b1, 32'h8,         32'hDEADBEEF, 32'h0,        1'b0};
      vecs[6]  = '{3'b010, 1'b0, 32'h8,         32'h0,        32'hDEADBEEF, 1'b0};
      vecs[7]  = '{3'b011, 1'b1, 32'h8,         32'h11111111, 32'h0,        1'b1};
      vecs[8]  = '{3'b010, 1'b1, 32'h2,         32'h22222222, 32'h0,        1'b1};
      vecs[9]  = '{3'b010, 1'b1, 32'h40,        32'h33333333, 32'h0,        1'b1};
      vecs[10] = '{3'b011, 1'b0, 32'h8,         32'h0,        32'h0,        1'b1};
      vecs[11] = '{3'b010, 1'b0, 32'h40,        32'h0,        32'h0,        1'b1};
      vecs[12] = '{3'b010, 1'b0, 32'h0,         32'h0,        32'h0,        1'b0};
      vecs[13] = '{3'b010, 1'b0, 32'h8,         32'h0,        32'hDEADBEEF, 1'b0};
      vecs[14] = '{3'b001, 1'b0, 32'h8,         32'h0,        32'h0000000A, 1'b0};
      vecs[15] = '{3'b100, 1'b1, 32'h3C,        32'h5A5A5A5A, 32'h0,        1'b0};
      vecs[16] = '{3'b100, 1'b0, 32'h3C,        32'h0,        32'h5A5A5A5A, 1'b0};
      vecs[17] = '{3'b010, 1'b0, 32'h10000008,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[18] = '{3'b100, 1'b0, 32'hFFC,       32'h0,        32'h0,        1'b1};
      vecs[19] = '{3'b001, 1'b0, 32'h3C,        32'h0,        32'h0,        1'b0};

      do_reset();
      @(negedge Hclk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_outputs_dut%0d", d),
             prdata_v[d] | {30'd0, pready_v[d], pslverr_v[d]}, 32'd0);
      end

      // Zero wait states: table of single transfers, issued back to back.
      cur = 0;
      for (int i = 0; i < 20; i++) begin
         apb(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, w);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_waits", i), w, 32'd0);
      end

      // Reset asserted while Pready/Prdata are high must clear them without a clock edge.
      @(posedge Hclk);
      #1; Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h8;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      @(negedge Hclk);
      chk("pre_async_pready", {31'd0, pready_v[0]}, 32'd1);
      chk("pre_async_prdata", prdata_v[0], 32'hDEADBEEF);
      #2 Hreset = 1'b1;
      #1;
      chk("async_pready", {31'd0, pready_v[0]}, 32'd0);
      chk("async_prdata", prdata_v[0], 32'd0);
      Pselx = '0; Penable = 1'b0;
      @(posedge Hclk);
      #1 Hreset = 1'b0;

      // Three wait states.
      cur = 1;
      do_reset();
      apb(3'b001, 1'b1, 32'h4, 32'h12345678, rd, er, w);
      chk("ws3_wr_waits", w, 32'd3);
      chk("ws3_wr_err", {31'd0, er}, 32'd0);
      apb(3'b001, 1'b0, 32'h4, 32'h0, rd, er, w);
      chk("ws3_rd_waits", w, 32'd3);
      chk("ws3_rd_data", rd, 32'h12345678);
      chk("ws3_rd_err", {31'd0, er}, 32'd0);

      // Abort a write mid-wait by dropping the select.
      bus_idle();
      @(posedge Hclk);
      #1; Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h20; Pwdata = 32'h99;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      @(negedge Hclk);
      chk("abort_wait_pready", {31'd0, pready_v[1]}, 32'd0);
      @(posedge Hclk);
      #1; Pselx = '0; Penable = 1'b0;
      repeat (2) begin
         @(negedge Hclk);
         chk("abort_idle_pready", {31'd0, pready_v[1]}, 32'd0);
      end
      apb(3'b010, 1'b0, 32'h20, 32'h0, rd, er, w);
      chk("abort_rd_data", rd, 32'd0);
      chk("abort_rd_waits", w, 32'd3);
      apb(3'b010, 1'b1, 32'h20, 32'hAB, rd, er, w);
      apb(3'b010, 1'b0, 32'h20, 32'h0, rd, er, w);
      chk("post_abort_rd_data", rd, 32'hAB);
      chk("post_abort_rd_err", {31'd0, er}, 32'd0);

      // Two wait states: reset during a write's wait state.
      cur = 2;
      do_reset();
      apb(3'b001, 1'b1, 32'h14, 32'h55, rd, er, w);
      chk("ws2_wr_waits", w, 32'd2);
      apb(3'b001, 1'b0, 32'h14, 32'h0, rd, er, w);
      chk("ws2_rd_data", rd, 32'h55);
      @(posedge Hclk);
      #1; Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h77;
      @(posedge Hclk);
      #1 Penable = 1'b1;
      @(negedge Hclk);
      chk("rst_wait_pready", {31'd0, pready_v[2]}, 32'd0);
      #2 Hreset = 1'b1;
      #1;
      chk("rst_outputs", prdata_v[2] | {30'd0, pready_v[2], pslverr_v[2]}, 32'd0);
      Pselx = '0; Penable = 1'b0;
      repeat (2) @(posedge Hclk);
      #1 Hreset = 1'b0;
      apb(3'b001, 1'b0, 32'h10, 32'h0, rd, er, w);
      chk("rst_target_word", rd, 32'd0);
      apb(3'b001, 1'b0, 32'h14, 32'h0, rd, er, w);
      chk("rst_cleared_word", rd, 32'd0);
      chk("rst_rd_waits", w, 32'd2);
      bus_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
